// File: rtl/irq_pkg.sv
// Shared CSR addresses, cause codes, bit positions and FSM states for the machine-mode interrupt controller.
package irq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int IRQ_MT_BIT   = 7;   // MTIP / MTIE
  localparam int IRQ_ME_BIT   = 11;  // MEIP / MEIE

  localparam logic [31:0] MTVEC_RESET_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_csr_regs.sv
// Interrupt CSR storage, write masking and combinational read mux; writes land one cycle after i_csr_we.
// Trap entry and mret updates take precedence over software writes to mstatus, mepc and mcause.
module irq_csr_regs
  import irq_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  input  logic [31:0] i_mip,
  input  logic        i_trap_take,
  input  logic [3:0]  i_trap_cause,
  input  logic [31:0] i_trap_pc,
  input  logic        i_mret,
  output logic        o_mstatus_mie,
  output logic        o_mie_mtie,
  output logic        o_mie_meie,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  logic        w_wr_mstatus;
  logic        w_wr_mie;
  logic        w_wr_mtvec;
  logic        w_wr_mepc;
  logic        w_wr_mcause;
  logic [31:0] w_mstatus;
  logic [31:0] w_mie;

  assign w_wr_mstatus = i_csr_we && (i_csr_addr == CSR_MSTATUS);
  assign w_wr_mie     = i_csr_we && (i_csr_addr == CSR_MIE);
  assign w_wr_mtvec   = i_csr_we && (i_csr_addr == CSR_MTVEC);
  assign w_wr_mepc    = i_csr_we && (i_csr_addr == CSR_MEPC);
  assign w_wr_mcause  = i_csr_we && (i_csr_addr == CSR_MCAUSE);

  // Trap entry beats mret if both arrive together; both beat software writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (i_trap_take) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (i_mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie  <= i_csr_wdata[MSTATUS_MIE];
      r_mpie <= i_csr_wdata[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtie  <= 1'b0;
      r_meie  <= 1'b0;
      r_mtvec <= MTVEC_RESET;
    end else begin
      if (w_wr_mie) begin
        r_mtie <= i_csr_wdata[IRQ_MT_BIT];
        r_meie <= i_csr_wdata[IRQ_ME_BIT];
      end
      if (w_wr_mtvec) begin
        r_mtvec <= {i_csr_wdata[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (i_trap_take) begin
      r_mepc   <= {i_trap_pc[31:2], 2'b00};
      r_mcause <= {1'b1, 27'b0, i_trap_cause};
    end else begin
      if (w_wr_mepc) begin
        r_mepc <= {i_csr_wdata[31:2], 2'b00};
      end
      if (w_wr_mcause) begin
        r_mcause <= i_csr_wdata;
      end
    end
  end

  always_comb begin
    w_mstatus               = '0;
    w_mstatus[MSTATUS_MIE]  = r_mie;
    w_mstatus[MSTATUS_MPIE] = r_mpie;
    w_mie                   = '0;
    w_mie[IRQ_MT_BIT]       = r_mtie;
    w_mie[IRQ_ME_BIT]       = r_meie;
  end

  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_addr)
      CSR_MSTATUS: o_csr_rdata = w_mstatus;
      CSR_MIE:     o_csr_rdata = w_mie;
      CSR_MTVEC:   o_csr_rdata = r_mtvec;
      CSR_MEPC:    o_csr_rdata = r_mepc;
      CSR_MCAUSE:  o_csr_rdata = r_mcause;
      CSR_MIP:     o_csr_rdata = i_mip;
      default:     o_csr_rdata = '0;
    endcase
  end

  assign o_mstatus_mie = r_mie;
  assign o_mie_mtie    = r_mtie;
  assign o_mie_meie    = r_meie;
  assign o_mtvec       = r_mtvec;
  assign o_mepc        = r_mepc;

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: pending latch, enable gating, priority and trap FSM; request 2 cycles after an irq.
// irq_req holds until acked or until the enable condition drops; acks without a request are ignored.
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = MTVEC_RESET_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_timer_irq,
  input  logic        i_ext_irq,
  input  logic        i_csr_we,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  output logic [31:0] o_csr_rdata,
  input  logic [31:0] i_trap_pc,
  output logic        o_irq_req,
  input  logic        i_irq_ack,
  output logic [31:0] o_irq_target,
  input  logic        i_mret,
  output logic [31:0] o_epc
);

  irq_state_e  r_state;
  irq_state_e  w_state_nxt;
  logic        r_irq_req;
  logic        r_mtip;
  logic        r_meip;

  logic        w_mstatus_mie;
  logic        w_mtie;
  logic        w_meie;
  logic        w_pend_tim;
  logic        w_pend_ext;
  logic        w_enable;
  logic        w_take;
  logic [3:0]  w_cause;
  logic [31:0] w_mip;

  assign w_pend_tim = r_mtip & w_mtie;
  assign w_pend_ext = r_meip & w_meie;
  assign w_enable   = w_mstatus_mie & (w_pend_tim | w_pend_ext);
  assign w_take     = r_irq_req & i_irq_ack;
  assign w_cause    = w_pend_ext ? CAUSE_MEI : CAUSE_MTI;

  always_comb begin
    w_mip             = '0;
    w_mip[IRQ_MT_BIT] = r_mtip;
    w_mip[IRQ_ME_BIT] = r_meip;
  end

  // A new timer pulse on the clearing edge keeps MTIP set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= i_timer_irq | (r_mtip & ~(w_take && (w_cause == CAUSE_MTI)));
      r_meip <= i_ext_irq;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_irq_req <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_req <= (w_state_nxt == REQ);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!i_mret && w_enable) w_state_nxt = REQ;
      end
      REQ: begin
        if (w_take)                    w_state_nxt = HANDLER;
        else if (i_mret || !w_enable)  w_state_nxt = IDLE;
      end
      HANDLER: begin
        if (i_mret) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  irq_csr_regs #(
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr_regs (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_csr_we      (i_csr_we),
    .i_csr_addr    (i_csr_addr),
    .i_csr_wdata   (i_csr_wdata),
    .o_csr_rdata   (o_csr_rdata),
    .i_mip         (w_mip),
    .i_trap_take   (w_take),
    .i_trap_cause  (w_cause),
    .i_trap_pc     (i_trap_pc),
    .i_mret        (i_mret),
    .o_mstatus_mie (w_mstatus_mie),
    .o_mie_mtie    (w_mtie),
    .o_mie_meie    (w_meie),
    .o_mtvec       (o_irq_target),
    .o_mepc        (o_epc)
  );

  assign o_irq_req = r_irq_req;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: timer path, priority, masking/withdraw, collisions, async reset and write masks.
module tb_irq_controller;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        timer_irq = 1'b0;
  logic        ext_irq   = 1'b0;
  logic        csr_we    = 1'b0;
  logic [11:0] csr_addr  = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] trap_pc   = '0;
  logic        irq_ack   = 1'b0;
  logic        mret      = 1'b0;
  logic [31:0] csr_rdata;
  logic        irq_req;
  logic [31:0] irq_target;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  irq_controller dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_timer_irq  (timer_irq),
    .i_ext_irq    (ext_irq),
    .i_csr_we     (csr_we),
    .i_csr_addr   (csr_addr),
    .i_csr_wdata  (csr_wdata),
    .o_csr_rdata  (csr_rdata),
    .i_trap_pc    (trap_pc),
    .o_irq_req    (irq_req),
    .i_irq_ack    (irq_ack),
    .o_irq_target (irq_target),
    .i_mret       (mret),
    .o_epc        (epc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic exp);
    chk(tag, {31'b0, irq_req}, {31'b0, exp});
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    step();
    csr_we    = 1'b0;
  endtask

  task automatic pulse_timer();
    timer_irq = 1'b1;
    step();
    timer_irq = 1'b0;
  endtask

  task automatic ack(input logic [31:0] pc);
    trap_pc = pc;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk_req("rst_req", 1'b0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_target", irq_target, 32'h100);
    rd("rst_mstatus", A_MSTATUS, 32'h0);
    rd("rst_mcause", A_MCAUSE, 32'h0);
    rd("rst_mip", A_MIP, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Write masks
    wr(A_MSTATUS, 32'hFFFF_FFFF); rd("mask_mstatus", A_MSTATUS, 32'h88);
    wr(A_MIE, 32'hFFFF_FFFF);     rd("mask_mie", A_MIE, 32'h880);
    wr(A_MIP, 32'hFFFF_FFFF);     rd("mask_mip", A_MIP, 32'h0);
    wr(A_MTVEC, 32'hFFFF_FFFF);   rd("mask_mtvec", A_MTVEC, 32'hFFFF_FFFC);
    wr(A_MEPC, 32'hFFFF_FFFF);    rd("mask_mepc", A_MEPC, 32'hFFFF_FFFC);
    wr(A_MCAUSE, 32'hFFFF_FFFF);  rd("mask_mcause", A_MCAUSE, 32'hFFFF_FFFF);
    chk("mask_target", irq_target, 32'hFFFF_FFFC);
    chk("mask_epc", epc, 32'hFFFF_FFFC);
    rd("unimpl_rd", 12'h123, 32'h0);
    chk_req("mask_noreq", 1'b0);
    wr(A_MTVEC, 32'h0000_0200);
    wr(A_MEPC, 32'h0);
    wr(A_MCAUSE, 32'h0);
    wr(A_MIE, 32'h0);

    // Timer path: MIE=1, MTIE=1
    wr(A_MSTATUS, 32'h8);
    wr(A_MIE, 32'h80);
    pulse_timer();
    chk_req("tim_e0_req", 1'b0);
    rd("tim_mip_set", A_MIP, 32'h80);
    step();
    chk_req("tim_e1_req", 1'b1);
    ack(32'h40);
    chk_req("tim_ack_req", 1'b0);
    chk("tim_epc", epc, 32'h40);
    chk("tim_target", irq_target, 32'h200);
    rd("tim_mcause", A_MCAUSE, 32'h8000_0007);
    rd("tim_mstatus", A_MSTATUS, 32'h80);
    rd("tim_mip_clr", A_MIP, 32'h0);
    step();
    chk_req("tim_handler_req", 1'b0);
    do_mret();
    rd("tim_mret_mstatus", A_MSTATUS, 32'h88);
    chk_req("tim_mret_req", 1'b0);

    // Priority: external over timer
    wr(A_MSTATUS, 32'h0);
    pulse_timer();
    wr(A_MIE, 32'h880);
    ext_irq = 1'b1;
    step();
    chk_req("pri_masked_req", 1'b0);
    wr(A_MSTATUS, 32'h8);
    chk_req("pri_w_req", 1'b0);
    step();
    chk_req("pri_req", 1'b1);
    ack(32'h60);
    rd("pri_mcause_ext", A_MCAUSE, 32'h8000_000B);
    rd("pri_mip", A_MIP, 32'h880);
    chk("pri_epc", epc, 32'h60);
    ext_irq = 1'b0;
    step();
    do_mret();
    chk_req("pri_mret_req", 1'b0);
    step();
    chk_req("pri_tim_req", 1'b1);
    ack(32'h80);
    rd("pri_mcause_tim", A_MCAUSE, 32'h8000_0007);
    rd("pri_mip_clr", A_MIP, 32'h0);
    chk("pri_epc2", epc, 32'h80);
    do_mret();

    // Masking and withdraw
    wr(A_MSTATUS, 32'h0);
    pulse_timer();
    for (int i = 0; i < 20; i++) begin
      step();
      chk_req("mask_hold_req", 1'b0);
    end
    wr(A_MSTATUS, 32'h8);
    chk_req("wd_w_req", 1'b0);
    step();
    chk_req("wd_req", 1'b1);
    wr(A_MIE, 32'h800);
    chk_req("wd_still_req", 1'b1);
    step();
    chk_req("wd_dropped", 1'b0);
    ack(32'hA0);
    rd("stray_ack_mcause", A_MCAUSE, 32'h8000_0007);
    rd("stray_ack_mstatus", A_MSTATUS, 32'h08);
    chk("stray_ack_epc", epc, 32'h80);

    // Collisions on the ack edge
    wr(A_MIE, 32'h880);
    step();
    chk_req("col_req", 1'b1);
    timer_irq = 1'b1;
    csr_we    = 1'b1;
    csr_addr  = A_MSTATUS;
    csr_wdata = 32'h8;
    ack(32'hC0);
    timer_irq = 1'b0;
    csr_we    = 1'b0;
    rd("col_mip", A_MIP, 32'h80);
    rd("col_mstatus", A_MSTATUS, 32'h80);
    rd("col_mcause", A_MCAUSE, 32'h8000_0007);
    chk("col_epc", epc, 32'hC0);

    // Async reset mid-HANDLER
    #2 rst_n = 1'b0;
    #1;
    chk_req("arst_req", 1'b0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_target", irq_target, 32'h100);
    rd("arst_mip", A_MIP, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Async reset mid-REQ
    wr(A_MSTATUS, 32'h8);
    wr(A_MIE, 32'h80);
    pulse_timer();
    step();
    chk_req("rreq_req", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_req("rreq_arst_req", 1'b0);
    rd("rreq_arst_mstatus", A_MSTATUS, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk_req("rreq_after_req", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
